// File: rtl/uart_mem_dump_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_mem_dump_if
// Description : Read-only bus between the memory dumper and the RIB master
//               port. The dumper drives the request and address side, the
//               memory returns read data combinationally.
//   req_o       - bus request (master -> slave)
//   mem_we_o    - write enable (master -> slave)
//   mem_addr_o  - 32-bit word address (master -> slave)
//   mem_rdata_i - 32-bit read data (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_mem_dump_if;
    logic        req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;

    modport master (
        output req_o,
        output mem_we_o,
        output mem_addr_o,
        input  mem_rdata_i
    );

    modport slave (
        input  req_o,
        input  mem_we_o,
        input  mem_addr_o,
        output mem_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/uart_mem_dump.sv
`default_nettype none
// ============================================================================
// Module      : uart_mem_dump
// Description : Reads a block of 32-bit words over the RIB bus and streams
//               every word out of a UART transmitter, 8N1, little-endian
//               byte order.
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset
//   start_i     - one-cycle pulse starting a dump (ignored while busy)
//   base_addr_i - first word address, sampled on an accepted start
//   word_cnt_i  - number of words, sampled on an accepted start
//   bus         - RIB master modport (req_o, mem_we_o, mem_addr_o, mem_rdata_i)
//   tx_pin      - UART transmit line, idle high
//   busy_o      - dump in progress
//   done_o      - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mem_dump #(
    parameter int BAUD_DIV = 434
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [31:0]     base_addr_i,
    input  logic [15:0]     word_cnt_i,
    uart_mem_dump_if.master bus,
    output logic            tx_pin,
    output logic            busy_o,
    output logic            done_o
);

    localparam int c_BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ADDR  = 3'd1,
        S_RD_DATA  = 3'd2,
        S_TX_START = 3'd3,
        S_TX_BIT   = 3'd4,
        S_TX_STOP  = 3'd5,
        S_NEXT     = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_BAUD_W-1:0]   r_baud;
    logic [2:0]            r_bit_cnt;
    logic [1:0]            r_byte_cnt;
    logic [15:0]           r_remaining;
    logic [31:0]           r_mem_addr;
    logic [31:0]           r_shift;
    logic                  r_zero_done;

    logic                  w_accept;
    logic                  w_bit_end;
    logic                  w_in_tx;
    logic                  w_last;
    logic                  w_req;
    logic                  w_tx;

    // A zero-count completion pulse blocks a start in the same cycle, just
    // like the NEXT-state completion does by not being in IDLE.
    assign w_accept  = start_i && (r_state == S_IDLE) && !r_zero_done;
    assign w_in_tx   = (r_state == S_TX_START) || (r_state == S_TX_BIT) ||
                       (r_state == S_TX_STOP);
    assign w_bit_end = w_in_tx && (r_baud == c_BAUD_LAST);
    // r_remaining counts the word just sent, so 1 means nothing left after it.
    assign w_last    = (r_state == S_NEXT) && (r_remaining == 16'd1);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_tx         = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (word_cnt_i != 16'd0)) begin
                    w_state_next = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                w_req        = 1'b1;
                w_state_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                w_req        = 1'b1;
                w_state_next = S_TX_START;
            end
            S_TX_START: begin
                w_tx = 1'b0;
                if (w_bit_end) begin
                    w_state_next = S_TX_BIT;
                end
            end
            S_TX_BIT: begin
                // Data leaves from bit 0 of the buffer, which shifts right
                // after every data bit, so the word goes out LSB-first.
                w_tx = r_shift[0];
                if (w_bit_end && (r_bit_cnt == 3'd7)) begin
                    w_state_next = S_TX_STOP;
                end
            end
            S_TX_STOP: begin
                if (w_bit_end) begin
                    w_state_next = (r_byte_cnt == 2'd3) ? S_NEXT : S_TX_START;
                end
            end
            S_NEXT: begin
                w_state_next = w_last ? S_IDLE : S_RD_ADDR;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: address, word counter, shift buffer, bit timing
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud      <= '0;
            r_bit_cnt   <= 3'd0;
            r_byte_cnt  <= 2'd0;
            r_remaining <= 16'd0;
            r_mem_addr  <= 32'd0;
            r_shift     <= 32'd0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= w_accept && (word_cnt_i == 16'd0);

            if (w_accept) begin
                r_remaining <= word_cnt_i;
                // The address output only moves when a read is about to happen.
                if (word_cnt_i != 16'd0) begin
                    r_mem_addr <= base_addr_i;
                end
            end else if (r_state == S_NEXT) begin
                r_remaining <= r_remaining - 16'd1;
                if (!w_last) begin
                    r_mem_addr <= r_mem_addr + 32'd4;
                end
            end

            if (r_state == S_RD_DATA) begin
                r_shift <= bus.mem_rdata_i;
            end else if ((r_state == S_TX_BIT) && w_bit_end) begin
                r_shift <= {1'b0, r_shift[31:1]};
            end

            // Free-running within the frame so consecutive bytes abut.
            if (w_in_tx && !w_bit_end) begin
                r_baud <= r_baud + c_BAUD_W'(1);
            end else begin
                r_baud <= '0;
            end

            if ((r_state == S_TX_BIT) && w_bit_end) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if ((r_state == S_TX_STOP) && w_bit_end) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
        end
    end

    assign bus.req_o      = w_req;
    assign bus.mem_we_o   = 1'b0;
    assign bus.mem_addr_o = r_mem_addr;
    assign tx_pin         = w_tx;
    assign busy_o         = (r_state != S_IDLE) && !w_last;
    assign done_o         = w_last || r_zero_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_dump.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mem_dump
// Description : Self-checking bench for uart_mem_dump. A reference timeline
//               of every output is computed per dump from word count, base
//               address and memory contents, then compared cycle by cycle
//               against the captured DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mem_dump;

    localparam int B    = 4;
    localparam int PER  = 3 + 40 * B;   // cycles per word including NEXT
    localparam int NMAX = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] word_cnt_i;
    logic        tx_pin;
    logic        busy_o;
    logic        done_o;

    uart_mem_dump_if bus_if ();

    uart_mem_dump #(.BAUD_DIV(B)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .word_cnt_i  (word_cnt_i),
        .bus         (bus_if),
        .tx_pin      (tx_pin),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    int          tests  = 0;
    int          failed = 0;
    logic [31:0] mem_seed;
    logic        ovr_en;
    logic [31:0] ovr_addr;
    logic [31:0] ovr_val;
    logic [31:0] model_addr;
    int          n_cap;
    // Signal index: 0 tx, 1 req, 2 addr, 3 busy, 4 done, 5 we
    logic [31:0] act_v [6][NMAX];
    logic [31:0] exp_v [6][NMAX];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr_en && (a == ovr_addr)) return ovr_val;
        return ((a ^ mem_seed) * 32'h9E37_79B1) + 32'h7F4A_7C15;
    endfunction

    always @(bus_if.mem_addr_o or mem_seed or ovr_en or ovr_addr or ovr_val)
        bus_if.mem_rdata_i = mem_word(bus_if.mem_addr_o);

    function automatic string sig_name(input int s);
        case (s)
            0: return "tx_pin";
            1: return "req_o";
            2: return "mem_addr_o";
            3: return "busy_o";
            4: return "done_o";
            default: return "mem_we_o";
        endcase
    endfunction

    function automatic int diff_at(input int s);
        for (int k = 0; k < n_cap; k++)
            if (act_v[s][k] !== exp_v[s][k]) return k;
        return -1;
    endfunction

    // Expected timeline: per word two request cycles, 40 bit times of
    // serial data, one bookkeeping cycle; then idle.
    task automatic build_model(input logic [31:0] base, input int cnt);
        logic [31:0] a;
        logic [31:0] w;
        int c, q, j, p;
        n_cap = cnt * PER + 5;
        for (int k = 0; k < n_cap; k++) begin
            exp_v[0][k] = 32'd1; exp_v[1][k] = 32'd0; exp_v[2][k] = model_addr;
            exp_v[3][k] = 32'd0; exp_v[4][k] = 32'd0; exp_v[5][k] = 32'd0;
        end
        if (cnt == 0) exp_v[4][0] = 32'd1;
        for (int i = 0; i < cnt; i++) begin
            a = base + 32'(4 * i);
            w = mem_word(a);
            for (int k = 0; k < PER; k++) begin
                c = i * PER + k;
                exp_v[3][c] = 32'd1;
                if (k < 2) begin
                    exp_v[1][c] = 32'd1;
                end else if (k < 2 + 40 * B) begin
                    q = k - 2;
                    j = q / (10 * B);
                    p = (q % (10 * B)) / B;
                    if (p == 0)      exp_v[0][c] = 32'd0;
                    else if (p <= 8) exp_v[0][c] = {31'd0, w[8 * j + p - 1]};
                end else begin
                    exp_v[3][c] = {31'd0, (i != cnt - 1)};
                    exp_v[4][c] = {31'd0, (i == cnt - 1)};
                end
            end
            for (int c2 = i * PER; c2 < n_cap; c2++) exp_v[2][c2] = a;
            model_addr = a;
        end
    endtask

    // Starts a dump and records n_cap cycles; optionally re-pulses start_i
    // at capture cycle rep_at with different parameters.
    task automatic run_dump(input logic [31:0] base, input logic [15:0] cnt,
                            input int rep_at, input logic [31:0] rep_base,
                            input logic [15:0] rep_cnt);
        build_model(base, int'(cnt));
        @(negedge clk);
        start_i = 1'b1; base_addr_i = base; word_cnt_i = cnt;
        for (int k = 0; k < n_cap; k++) begin
            @(negedge clk);
            act_v[0][k] = {31'd0, tx_pin};
            act_v[1][k] = {31'd0, bus_if.req_o};
            act_v[2][k] = bus_if.mem_addr_o;
            act_v[3][k] = {31'd0, busy_o};
            act_v[4][k] = {31'd0, done_o};
            act_v[5][k] = {31'd0, bus_if.mem_we_o};
            if (k == rep_at) begin
                start_i = 1'b1; base_addr_i = rep_base; word_cnt_i = rep_cnt;
            end else begin
                start_i = 1'b0; base_addr_i = $urandom; word_cnt_i = 16'($urandom);
            end
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (tx_pin !== 1'b1) begin failed++; $display("FAIL reset tx_pin: got %b expected 1", tx_pin); end
        tests++; if (bus_if.req_o !== 1'b0) begin failed++; $display("FAIL reset req_o: got %b expected 0", bus_if.req_o); end
        tests++; if (bus_if.mem_we_o !== 1'b0) begin failed++; $display("FAIL reset mem_we_o: got %b expected 0", bus_if.mem_we_o); end
        tests++; if (busy_o !== 1'b0) begin failed++; $display("FAIL reset busy_o: got %b expected 0", busy_o); end
        tests++; if (done_o !== 1'b0) begin failed++; $display("FAIL reset done_o: got %b expected 0", done_o); end
        tests++; if (bus_if.mem_addr_o !== 32'd0) begin failed++; $display("FAIL reset mem_addr_o: got %h expected 0", bus_if.mem_addr_o); end
        rst = 1'b0;
        model_addr = 32'd0;
    endtask

    task automatic test_single_word;
        logic [31:0] got;
        int d, nreq, ndone;
        ovr_en = 1'b1; ovr_addr = 32'h1000_0000; ovr_val = 32'h4433_2211;
        run_dump(32'h1000_0000, 16'd1, -1, 32'd0, 16'd0);
        for (int s = 0; s < 6; s++) begin
            d = diff_at(s);
            tests++;
            if (d >= 0) begin failed++; $display("FAIL single_word %s cycle %0d: got %h expected %h", sig_name(s), d, act_v[s][d], exp_v[s][d]); end
        end
        got = 32'd0; nreq = 0; ndone = 0;
        for (int j = 0; j < 4; j++)
            for (int b = 0; b < 8; b++)
                got[8 * j + b] = act_v[0][2 + j * 10 * B + (1 + b) * B + B / 2][0];
        for (int k = 0; k < n_cap; k++) begin
            if (act_v[1][k][0] === 1'b1) nreq++;
            if (act_v[4][k][0] === 1'b1) ndone++;
        end
        tests++; if (got !== 32'h4433_2211) begin failed++; $display("FAIL single_word bytes: got %h expected 44332211", got); end
        tests++; if (nreq !== 2) begin failed++; $display("FAIL single_word req cycles: got %0d expected 2", nreq); end
        tests++; if (ndone !== 1) begin failed++; $display("FAIL single_word done pulses: got %0d expected 1", ndone); end
        ovr_en = 1'b0;
    endtask

    task automatic test_multi_word;
        int d, nreq;
        mem_seed = $urandom;
        run_dump(32'h0000_0100, 16'd3, -1, 32'd0, 16'd0);
        for (int s = 0; s < 6; s++) begin
            d = diff_at(s);
            tests++;
            if (d >= 0) begin failed++; $display("FAIL multi_word %s cycle %0d: got %h expected %h", sig_name(s), d, act_v[s][d], exp_v[s][d]); end
        end
        nreq = 0;
        for (int k = 0; k < n_cap; k++) if (act_v[1][k][0] === 1'b1) nreq++;
        tests++; if (nreq !== 6) begin failed++; $display("FAIL multi_word req cycles: got %0d expected 6", nreq); end
    endtask

    task automatic test_zero_count;
        int d;
        // Second start lands in the completion cycle and must be dropped.
        run_dump(32'h0000_2000, 16'd0, 0, 32'h0000_3000, 16'd1);
        for (int s = 0; s < 6; s++) begin
            d = diff_at(s);
            tests++;
            if (d >= 0) begin failed++; $display("FAIL zero_count %s cycle %0d: got %h expected %h", sig_name(s), d, act_v[s][d], exp_v[s][d]); end
        end
    endtask

    task automatic test_addr_wrap;
        int d;
        mem_seed = $urandom;
        run_dump(32'hFFFF_FFFC, 16'd2, -1, 32'd0, 16'd0);
        for (int s = 0; s < 6; s++) begin
            d = diff_at(s);
            tests++;
            if (d >= 0) begin failed++; $display("FAIL addr_wrap %s cycle %0d: got %h expected %h", sig_name(s), d, act_v[s][d], exp_v[s][d]); end
        end
        tests++; if (act_v[2][PER] !== 32'd0) begin failed++; $display("FAIL addr_wrap second read: got %h expected 00000000", act_v[2][PER]); end
    endtask

    task automatic test_restart_ignored;
        int d;
        mem_seed = $urandom;
        run_dump(32'h0000_0100, 16'd2, 60, 32'hDEAD_0000, 16'd5);
        for (int s = 0; s < 6; s++) begin
            d = diff_at(s);
            tests++;
            if (d >= 0) begin failed++; $display("FAIL restart_ignored %s cycle %0d: got %h expected %h", sig_name(s), d, act_v[s][d], exp_v[s][d]); end
        end
    endtask

    task automatic test_done_collision;
        int d;
        mem_seed = $urandom;
        run_dump(32'h0000_4000, 16'd1, PER - 1, 32'h0000_5000, 16'd1);
        for (int s = 0; s < 6; s++) begin
            d = diff_at(s);
            tests++;
            if (d >= 0) begin failed++; $display("FAIL done_collision %s cycle %0d: got %h expected %h", sig_name(s), d, act_v[s][d], exp_v[s][d]); end
        end
        // start held three cycles on a zero-count dump: accepted, dropped, accepted.
        @(negedge clk);
        start_i = 1'b1; word_cnt_i = 16'd0; base_addr_i = 32'h0000_6000;
        @(negedge clk);
        tests++; if (done_o !== 1'b1) begin failed++; $display("FAIL done_collision first pulse: got %b expected 1", done_o); end
        @(negedge clk);
        tests++; if (done_o !== 1'b0) begin failed++; $display("FAIL done_collision same-cycle start: got %b expected 0", done_o); end
        @(negedge clk);
        start_i = 1'b0;
        tests++; if (done_o !== 1'b1) begin failed++; $display("FAIL done_collision next-cycle start: got %b expected 1", done_o); end
        @(negedge clk);
        tests++; if (done_o !== 1'b0) begin failed++; $display("FAIL done_collision tail: got %b expected 0", done_o); end
    endtask

    task automatic test_reset_midbyte;
        int d;
        logic bad;
        mem_seed = $urandom;
        build_model(32'h2000_0000, 1);
        @(negedge clk);
        start_i = 1'b1; base_addr_i = 32'h2000_0000; word_cnt_i = 16'd1;
        for (int k = 0; k <= 2 + 2 * B + 1; k++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        tests++; if ({31'd0, tx_pin} !== exp_v[0][2 + 2 * B + 1]) begin failed++; $display("FAIL reset_midbyte data bit: got %b expected %h", tx_pin, exp_v[0][2 + 2 * B + 1]); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (tx_pin !== 1'b1) begin failed++; $display("FAIL reset_midbyte tx_pin: got %b expected 1", tx_pin); end
        tests++; if (busy_o !== 1'b0) begin failed++; $display("FAIL reset_midbyte busy_o: got %b expected 0", busy_o); end
        tests++; if (done_o !== 1'b0) begin failed++; $display("FAIL reset_midbyte done_o: got %b expected 0", done_o); end
        tests++; if (bus_if.req_o !== 1'b0) begin failed++; $display("FAIL reset_midbyte req_o: got %b expected 0", bus_if.req_o); end
        tests++; if (bus_if.mem_addr_o !== 32'd0) begin failed++; $display("FAIL reset_midbyte mem_addr_o: got %h expected 0", bus_if.mem_addr_o); end
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_o !== 1'b0 || tx_pin !== 1'b1) bad = 1'b1;
        end
        tests++; if (bad !== 1'b0) begin failed++; $display("FAIL reset_midbyte quiet line: got %b expected 0", bad); end
        model_addr = 32'd0;
        ovr_en = 1'b1; ovr_addr = 32'h1000_0000; ovr_val = 32'h4433_2211;
        run_dump(32'h1000_0000, 16'd1, -1, 32'd0, 16'd0);
        for (int s = 0; s < 6; s++) begin
            d = diff_at(s);
            tests++;
            if (d >= 0) begin failed++; $display("FAIL reset_midbyte rerun %s cycle %0d: got %h expected %h", sig_name(s), d, act_v[s][d], exp_v[s][d]); end
        end
        ovr_en = 1'b0;
    endtask

    task automatic test_random;
        int d, cnt, rep;
        logic [31:0] base;
        for (int it = 0; it < 5; it++) begin
            mem_seed = $urandom;
            base = $urandom & 32'hFFFF_FFFC;
            cnt  = int'($urandom_range(0, 3));
            rep  = (cnt == 0) ? 0 : int'($urandom_range(0, cnt * PER - 1));
            run_dump(base, 16'(cnt), rep, $urandom, 16'($urandom_range(1, 65535)));
            for (int s = 0; s < 6; s++) begin
                d = diff_at(s);
                tests++;
                if (d >= 0) begin failed++; $display("FAIL random[%0d] cnt=%0d %s cycle %0d: got %h expected %h", it, cnt, sig_name(s), d, act_v[s][d], exp_v[s][d]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; base_addr_i = 32'd0; word_cnt_i = 16'd0;
        mem_seed = 32'h1234_5678; ovr_en = 1'b0; ovr_addr = 32'd0; ovr_val = 32'd0;
        model_addr = 32'd0; n_cap = 0;
        test_reset;
        test_single_word;
        test_multi_word;
        test_zero_count;
        test_addr_wrap;
        test_restart_ignored;
        test_done_collision;
        test_reset_midbyte;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
